// File: rtl/mncrst_pkg.sv
// mncrst_pkg: shared ROM region map, sequencer state encoding and region lookup.
//   PROG_BASE/GFX_BASE/PROM_BASE/PROM_LIMIT : download address map
//   ROM_AW                                  : width of a region-local ROM address
//   seq_state_t                             : BOOT, LOAD, SETTLE, RUN, ERR
//   region_t / region_of()                  : which region a download address falls in
package mncrst_pkg;

    localparam logic [15:0] PROG_BASE  = 16'h0000;
    localparam logic [15:0] GFX_BASE   = 16'h4000;
    localparam logic [15:0] PROM_BASE  = 16'h6000;
    localparam logic [15:0] PROM_LIMIT = 16'h6020;
    localparam int          ROM_AW     = 14;

    typedef enum logic [2:0] {
        BOOT,
        LOAD,
        SETTLE,
        RUN,
        ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        RG_PROG,
        RG_GFX,
        RG_PROM,
        RG_NONE
    } region_t;

    // Bytes at or above PROM_LIMIT belong to no region: counted, never written.
    function automatic region_t region_of(input logic [15:0] addr);
        return addr < GFX_BASE   ? RG_PROG :
               addr < PROM_BASE  ? RG_GFX  :
               addr < PROM_LIMIT ? RG_PROM : RG_NONE;
    endfunction

endpackage

// File: rtl/dl_rom_sequencer_if.sv
// dl_rom_sequencer_if: HPS download bus in, ROM write bus out.
//   dn_download : download session active
//   dn_wr       : single-cycle byte write strobe
//   dn_addr     : linear download byte address
//   dn_data     : download byte
//   prog_we/gfx_we/prom_we : per-region ROM write enables
//   rom_addr    : region-local ROM address
//   rom_data    : ROM write data
// master = download source (HPS side), slave = sequencer.
interface dl_rom_sequencer_if;
    import mncrst_pkg::*;

    logic              dn_download;
    logic              dn_wr;
    logic [15:0]       dn_addr;
    logic [7:0]        dn_data;
    logic              prog_we;
    logic              gfx_we;
    logic              prom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output dn_download, dn_wr, dn_addr, dn_data,
        input  prog_we, gfx_we, prom_we, rom_addr, rom_data
    );

    modport slave (
        input  dn_download, dn_wr, dn_addr, dn_data,
        output prog_we, gfx_we, prom_we, rom_addr, rom_data
    );

endinterface

// File: rtl/rom_region_decode.sv
// rom_region_decode: combinational download-address to region select and region-local offset.
//   addr   : linear download byte address
//   region : RG_PROG / RG_GFX / RG_PROM / RG_NONE
//   offset : addr minus the region base, truncated to ROM_AW bits
module rom_region_decode
    import mncrst_pkg::*;
(
    input  logic [15:0]       addr,
    output region_t           region,
    output logic [ROM_AW-1:0] offset
);

    logic [15:0] base;

    always_comb begin
        region = region_of(addr);
        base   = region == RG_GFX  ? GFX_BASE  :
                 region == RG_PROM ? PROM_BASE : PROG_BASE;
        offset = ROM_AW'(addr - base);
    end

endmodule

// File: rtl/dl_rom_sequencer.sv
// dl_rom_sequencer: routes an HPS ROM download into program/graphics/PROM write
// strobes, validates the byte count and sequences the game-core reset.
//   clk_sys    : single clock
//   RESET_N    : asynchronous active-low reset
//   dl         : download bus in / ROM write bus out (slave modport)
//   reset_req  : level user/OSD reset request
//   core_reset : active-high core reset, low only in RUN
//   load_busy  : high in LOAD
//   load_err   : high in ERR (too few bytes downloaded)
module dl_rom_sequencer
    import mncrst_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int MIN_BYTES     = 24608
) (
    input  logic                     clk_sys,
    input  logic                     RESET_N,
    dl_rom_sequencer_if.slave        dl,
    input  logic                     reset_req,
    output logic                     core_reset,
    output logic                     load_busy,
    output logic                     load_err
);

    localparam int              SW            = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]   SETTLE_RELOAD = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]   SETTLE_FIRST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [15:0]     MIN_CNT       = 16'(MIN_BYTES);

    seq_state_t        state;
    seq_state_t        state_nx;
    logic              dl_prev;
    logic              dn_rise;
    logic              accept;
    logic [15:0]       byte_cnt;
    logic [15:0]       byte_cnt_nx;
    logic [15:0]       byte_cnt_inc;
    logic [SW-1:0]     settle_cnt;
    logic [SW-1:0]     settle_cnt_nx;
    region_t           region;
    logic [ROM_AW-1:0] offset;

    rom_region_decode u_decode (
        .addr   (dl.dn_addr),
        .region (region),
        .offset (offset)
    );

    assign dn_rise      = dl.dn_download && !dl_prev;
    assign accept       = state == LOAD && dl.dn_wr;
    assign byte_cnt_inc = byte_cnt == 16'hFFFF ? byte_cnt : byte_cnt + 16'd1;

    assign core_reset   = state != RUN;
    assign load_busy    = state == LOAD;
    assign load_err     = state == ERR;

    // Settle timing: the edge that samples dn_download low already counts as the
    // first settle cycle, so LOAD exit loads SETTLE_CYCLES-1. A reset_req holds the
    // counter one higher so that a full SETTLE_CYCLES follow its release.
    always_comb begin
        state_nx      = state;
        byte_cnt_nx   = accept ? byte_cnt_inc : byte_cnt;
        settle_cnt_nx = settle_cnt;
        if (dn_rise) begin
            state_nx    = LOAD;
            byte_cnt_nx = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (!dl.dn_download) begin
                        state_nx      = byte_cnt_nx >= MIN_CNT ? SETTLE : ERR;
                        settle_cnt_nx = SETTLE_FIRST;
                    end
                end
                SETTLE: begin
                    if (reset_req)
                        settle_cnt_nx = SETTLE_RELOAD;
                    else if (settle_cnt == '0)
                        state_nx = RUN;
                    else
                        settle_cnt_nx = settle_cnt - SW'(1);
                end
                RUN: begin
                    if (reset_req) begin
                        state_nx      = SETTLE;
                        settle_cnt_nx = SETTLE_RELOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // dl_prev resets high so a download still asserted across reset release is
    // not mistaken for a fresh rising edge.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= BOOT;
            dl_prev     <= 1'b1;
            byte_cnt    <= '0;
            settle_cnt  <= '0;
            dl.prog_we  <= 1'b0;
            dl.gfx_we   <= 1'b0;
            dl.prom_we  <= 1'b0;
            dl.rom_addr <= '0;
            dl.rom_data <= '0;
        end else begin
            state       <= state_nx;
            dl_prev     <= dl.dn_download;
            byte_cnt    <= byte_cnt_nx;
            settle_cnt  <= settle_cnt_nx;
            dl.prog_we  <= accept && region == RG_PROG;
            dl.gfx_we   <= accept && region == RG_GFX;
            dl.prom_we  <= accept && region == RG_PROM;
            if (accept && region != RG_NONE) begin
                dl.rom_addr <= offset;
                dl.rom_data <= dl.dn_data;
            end
        end
    end

endmodule

// File: tb/tb_dl_rom_sequencer.sv
// tb_dl_rom_sequencer: directed self-checking bench for dl_rom_sequencer.
module tb_dl_rom_sequencer;

    logic clk_sys = 1'b0;
    logic RESET_N;
    logic reset_req;
    logic core_reset;
    logic load_busy;
    logic load_err;

    int n_chk  = 0;
    int n_fail = 0;
    int pc     = 0;
    int gc     = 0;
    int rc     = 0;
    int n;
    int hi;

    dl_rom_sequencer_if dl ();

    dl_rom_sequencer dut (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .dl         (dl),
        .reset_req  (reset_req),
        .core_reset (core_reset),
        .load_busy  (load_busy),
        .load_err   (load_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled on the posedge, outputs
    // are observed at the following negedge and write pulses are tallied.
    task automatic cyc();
        @(negedge clk_sys);
        pc += int'(dl.prog_we);
        gc += int'(dl.gfx_we);
        rc += int'(dl.prom_we);
    endtask

    task automatic clr_counts();
        pc = 0;
        gc = 0;
        rc = 0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N        = 1'b0;
        reset_req      = 1'b0;
        dl.dn_download = 1'b0;
        dl.dn_wr       = 1'b0;
        dl.dn_addr     = '0;
        dl.dn_data     = '0;
        repeat (3) cyc();
        check("rst_core_reset", core_reset, 1);
        check("rst_we", {dl.prog_we, dl.gfx_we, dl.prom_we}, 0);
        check("rst_rom_addr", dl.rom_addr, 0);
        check("rst_rom_data", dl.rom_data, 0);
        check("rst_busy_err", {load_busy, load_err}, 0);

        // BOOT ignores reset_req and writes
        RESET_N   = 1'b1;
        reset_req = 1'b1;
        repeat (3) cyc();
        reset_req  = 1'b0;
        dl.dn_wr   = 1'b1;
        dl.dn_addr = 16'h0010;
        cyc();
        dl.dn_wr = 1'b0;
        check("boot_we_ignored", {dl.prog_we, dl.gfx_we, dl.prom_we}, 0);
        check("boot_state", {core_reset, load_busy, load_err}, 3'b100);

        // Short load of 0x1000 bytes -> ERR
        dl.dn_download = 1'b1;
        cyc();
        check("load_busy_rise", load_busy, 1);
        dl.dn_wr   = 1'b1;
        dl.dn_addr = 16'h4123;
        dl.dn_data = 8'hA5;
        cyc();
        check("gfx_we_pulse", {dl.prog_we, dl.gfx_we, dl.prom_we}, 3'b010);
        check("gfx_rom_addr", dl.rom_addr, 14'h0123);
        check("gfx_rom_data", dl.rom_data, 8'hA5);
        dl.dn_addr = 16'h6020;
        dl.dn_data = 8'h5A;
        cyc();
        check("beyond_limit_no_we", {dl.prog_we, dl.gfx_we, dl.prom_we}, 0);
        dl.dn_addr = 16'h6005;
        dl.dn_data = 8'h3C;
        cyc();
        check("prom_we_pulse", {dl.prog_we, dl.gfx_we, dl.prom_we}, 3'b001);
        check("prom_rom_addr", dl.rom_addr, 14'h0005);
        for (int i = 0; i < 16'h0FFD; i++) begin
            dl.dn_addr = 16'(i);
            dl.dn_data = 8'(i);
            cyc();
        end
        check("prog_we_last", dl.prog_we, 1);
        check("prog_rom_addr_last", dl.rom_addr, 14'h0FFC);
        check("prog_rom_data_last", dl.rom_data, 8'hFC);
        dl.dn_wr       = 1'b0;
        dl.dn_download = 1'b0;
        cyc();
        check("short_load_err", {core_reset, load_busy, load_err}, 3'b101);
        reset_req = 1'b1;
        repeat (5) cyc();
        reset_req = 1'b0;
        dl.dn_wr  = 1'b1;
        cyc();
        dl.dn_wr = 1'b0;
        cyc();
        check("err_holds", {core_reset, load_busy, load_err}, 3'b101);
        check("err_we_ignored", {dl.prog_we, dl.gfx_we, dl.prom_we}, 0);

        // 0x601F unmapped bytes, last one with download falling -> one short, ERR
        dl.dn_download = 1'b1;
        cyc();
        clr_counts();
        dl.dn_wr = 1'b1;
        for (int i = 0; i < 16'h601E; i++) begin
            dl.dn_addr = 16'h7000 + 16'(i);
            cyc();
        end
        dl.dn_addr     = 16'hFFFF;
        dl.dn_download = 1'b0;
        cyc();
        dl.dn_wr = 1'b0;
        check("min_minus_one_err", load_err, 1);
        check("unmapped_no_pulses", pc + gc + rc, 0);

        // Full 0x6020-byte load, last byte accepted as download falls -> SETTLE
        dl.dn_download = 1'b1;
        cyc();
        clr_counts();
        dl.dn_wr = 1'b1;
        for (int i = 0; i < 16'h601F; i++) begin
            dl.dn_addr = 16'(i);
            dl.dn_data = 8'(i);
            cyc();
        end
        dl.dn_addr     = 16'h601F;
        dl.dn_data     = 8'h1F;
        dl.dn_download = 1'b0;
        cyc();
        dl.dn_wr = 1'b0;
        check("full_settle", {core_reset, load_busy, load_err}, 3'b100);
        check("full_last_addr", dl.rom_addr, 14'h001F);
        n = 0;
        while (core_reset && n < 2000) begin
            cyc();
            n++;
        end
        check("settle_len", n, 1024);
        check("prog_pulses", pc, 16384);
        check("gfx_pulses", gc, 8192);
        check("prom_pulses", rc, 32);

        // RUN ignores writes
        dl.dn_wr   = 1'b1;
        dl.dn_addr = 16'h0042;
        cyc();
        dl.dn_wr = 1'b0;
        check("run_we_ignored", {dl.prog_we, dl.gfx_we, dl.prom_we}, 0);
        check("run_core_reset", core_reset, 0);

        // reset_req held 50 cycles in RUN
        reset_req = 1'b1;
        hi = 0;
        repeat (50) begin
            cyc();
            if (core_reset) hi++;
        end
        reset_req = 1'b0;
        n = 0;
        while (n < 3000) begin
            cyc();
            n++;
            if (!core_reset) break;
            hi++;
        end
        check("reset_req_hold", hi, 1074);

        // Re-download during SETTLE clears the byte count
        reset_req = 1'b1;
        cyc();
        reset_req = 1'b0;
        repeat (10) cyc();
        check("settle_again", {core_reset, load_busy}, 2'b10);
        dl.dn_download = 1'b1;
        cyc();
        check("settle_to_load", {core_reset, load_busy}, 2'b11);
        clr_counts();
        dl.dn_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dl.dn_addr = 16'h4000 + 16'(i);
            cyc();
        end
        dl.dn_wr       = 1'b0;
        dl.dn_download = 1'b0;
        cyc();
        check("cleared_count_err", load_err, 1);
        check("reload_gfx_pulses", gc, 4);

        // RESET_N mid-LOAD
        dl.dn_download = 1'b1;
        cyc();
        dl.dn_wr   = 1'b1;
        dl.dn_addr = 16'h0123;
        dl.dn_data = 8'h77;
        cyc();
        check("pre_reset_we", dl.prog_we, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_we", {dl.prog_we, dl.gfx_we, dl.prom_we}, 0);
        check("async_rom", {dl.rom_addr, dl.rom_data}, 0);
        check("async_state", {core_reset, load_busy, load_err}, 3'b100);
        dl.dn_wr = 1'b0;
        repeat (2) cyc();
        RESET_N = 1'b1;
        repeat (5) cyc();
        check("boot_after_reset", {core_reset, load_busy, load_err}, 3'b100);
        dl.dn_download = 1'b0;
        cyc();
        dl.dn_download = 1'b1;
        cyc();
        check("new_download", load_busy, 1);
        dl.dn_download = 1'b0;
        cyc();
        check("empty_load_err", load_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_rom_sequencer.md
DL_ROM_SEQUENCER -- requirements
Module: dl_rom_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1024, meaning core-reset hold length in clk_sys cycles after load or reset request.
REQ-002 SHALL have parameter MIN_BYTES, default 24608 (0x6020), meaning the minimum byte count for a valid ROM set.
REQ-003 SHALL have port clk_sys, input, 1, the single clock.
REQ-004 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port dn_download, input, 1, HPS download active.
REQ-006 SHALL have port dn_wr, input, 1, single-cycle byte write strobe.
REQ-007 SHALL have port dn_addr, input, 16, linear download byte address.
REQ-008 SHALL have port dn_data, input, 8, download byte.
REQ-009 SHALL have port reset_req, input, 1, level user/OSD reset request.
REQ-010 SHALL have port core_reset, output, 1, active-high reset to the game core.
REQ-011 SHALL have port prog_we, output, 1, program ROM write enable, 0x0000-0x3FFF.
REQ-012 SHALL have port gfx_we, output, 1, graphics ROM write enable, 0x4000-0x5FFF.
REQ-013 SHALL have port prom_we, output, 1, colour PROM write enable, 0x6000-0x601F.
REQ-014 SHALL have port rom_addr, output, 14, region-local address.
REQ-015 SHALL have port rom_data, output, 8, write data.
REQ-016 SHALL have port load_busy, output, 1, high in LOAD.
REQ-017 SHALL have port load_err, output, 1, high in ERR.

Function
REQ-018 SHALL implement FSM states BOOT, LOAD, SETTLE, RUN, ERR.
REQ-019 SHALL move from any state to LOAD, clearing the byte counter, on the cycle dn_download is first sampled high.
REQ-020 SHALL accept dn_wr only in LOAD; dn_wr in any other state is ignored.
REQ-021 SHALL register each accepted write: exactly one of prog_we, gfx_we, prom_we pulses for one cycle, one cycle after dn_wr, with rom_addr = dn_addr minus the region base, truncated to 14 bits, and rom_data = dn_data.
REQ-022 SHALL count, but not write, bytes at dn_addr >= 0x6020; all we outputs stay low for these.
REQ-023 SHALL keep a 16-bit byte counter of accepted writes, saturating at 0xFFFF.
REQ-024 SHALL leave LOAD when dn_download is sampled low; a dn_wr in that same cycle is still accepted and counted.
REQ-025 SHALL, on leaving LOAD, go to SETTLE if count (including any final write) >= MIN_BYTES, else to ERR.
REQ-026 SHALL, in SETTLE, count SETTLE_CYCLES cycles, then enter RUN.
REQ-027 SHALL, in RUN with reset_req high, enter SETTLE with the counter reloaded.
REQ-028 SHALL, in SETTLE with reset_req high, hold the counter at its reload value.
REQ-029 SHALL hold core_reset high in every state except RUN; core_reset falls on the cycle RUN is entered.
REQ-030 SHALL remain in BOOT and ERR until the next rising dn_download; reset_req has no effect in those states.

Reset
REQ-031 SHALL, while RESET_N is low: state = BOOT, core_reset = 1, all we = 0, rom_addr = 0, rom_data = 0, load_busy = 0, load_err = 0, counters = 0.
REQ-032 SHALL, on reset assertion mid-LOAD, abort the load; after release, a new rising dn_download is required to leave BOOT.

Structure
REQ-033 SHALL take region bases/limits (0x0000, 0x4000, 0x6000, 0x6020) and the state enum from shared package mncrst_pkg.
REQ-034 SHALL be a single module with one natural sub-module, rom_region_decode (combinational address-to-select/offset).

Verification
REQ-035 SHALL cover: full 0x6020-byte load -> 16384 prog_we, 8192 gfx_we, 32 prom_we pulses; core_reset falls exactly 1024 cycles after dn_download falls.
REQ-036 SHALL cover: write of 0xA5 at dn_addr 0x4123 -> next cycle gfx_we = 1, rom_addr = 0x0123, rom_data = 0xA5.
REQ-037 SHALL cover: load of 0x1000 bytes -> ERR, load_err = 1, core_reset stays 1; reset_req pulses ignored.
REQ-038 SHALL cover: reset_req held 50 cycles in RUN -> core_reset high for 50 + 1024 cycles.
REQ-039 SHALL cover: dn_download re-asserted during SETTLE -> LOAD, counter cleared, load_busy = 1 next cycle.
REQ-040 SHALL cover: RESET_N low mid-LOAD -> all outputs at reset values immediately; after release, stays in BOOT until a new download.
